// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer around a 1-bit ALU slice.
// Feeds operand bits LSB first and gathers F into a result register.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             m,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             alu_m,
  output logic             alu_s1,
  output logic             alu_s0,
  output logic             alu_a,
  output logic             alu_b,
  input  logic             alu_f,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [1:0]       op_q;
  logic             m_q;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));

  // Next-state selection; DONE always falls back to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand latching, serial shifting and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      op_q   <= '0;
      m_q    <= 1'b0;
      result <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            op_q   <= op;
            m_q    <= m;
            cnt    <= '0;
            result <= '0;
          end
        end
        (state == SHIFT): begin
          result <= {alu_f, result[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign alu_m  = m_q;
  assign alu_s1 = op_q[1];
  assign alu_s0 = op_q[0];
  assign alu_a  = (state == SHIFT) & a_sh[0];
  assign alu_b  = (state == SHIFT) & b_sh[0];
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);
  assign zero   = ~|result;

endmodule
